branch_resolve: RTL and testbench
=================================

Name: branch_resolve

Overview:
- Consumer end of the decoded branch/jump control codes produced in ID; sits in EX.
- Evaluates the branch condition, computes the redirect target, and produces the link write of pc+8 (r31 or rd).
- Runs a squash state machine that discards wrong-path instructions after a taken transfer.
- Single registered stage: results appear one cycle after acceptance.

Parameters:
- FLUSH_SLOTS, 2, number of accepted beats squashed after a taken transfer (0..15; 0 disables squash).
- LINK_REG, 31, link register index for jal/bgezal/bltzal.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  an instruction is presented this cycle
- stall  in  1  pipeline hold; no accept, all state frozen
- branch  in  4  0 bno, 1 beq, 2 bne, 3 bgez, 4 bgtz, 5 bgezal, 6 blez, 7 bltz, 8 bltzal; 9-15 treated as bno
- jal  in  2  0 jno, 1 j, 2 jal, 3 treated as jno
- jr  in  2  0 jrno, 1 jr, 2 jalr, 3 treated as jrno
- pc  in  32  pc of presented instruction
- imm16  in  16  branch offset (words)
- instr_index  in  26  j/jal index
- rs_val  in  32  forwarded rs
- rt_val  in  32  forwarded rt
- rd  in  5  jalr destination
- redirect  out  1  one-cycle pulse: take redirect_pc
- redirect_pc  out  32  target
- link_we  out  1  one-cycle pulse: write link_data to link_addr
- link_addr  out  5  link destination
- link_data  out  32  pc+8
- flush  out  1  high while state is SQUASH
- squash  out  1  one-cycle pulse: the beat accepted last cycle was discarded
- multi_err  out  1  one-cycle pulse: more than one of branch/jal/jr was non-null

Behaviour:
- Reset (async, rst_n=0): all outputs 0, state IDLE, counter 0. Reset mid-squash abandons it.
- accept = in_valid & !stall. With stall=1, nothing changes and pulse outputs drop to 0 after one cycle.
- Pulse outputs are 0 in any cycle not following an accept.

IDLE, accept (results registered at that edge, visible next cycle):
- Priority: jr > jal > branch. If more than one is non-null, pulse multi_err and use only the highest-priority one.
- jr/jalr: taken, target = rs_val.
- j/jal: taken, target = {pc_plus4[31:28], instr_index, 2'b00}, where pc_plus4 = pc+4.
- Branch: target = pc + 4 + (sext(imm16) << 2), 32-bit wraparound, no overflow flag.
- Conditions (rs_val and rt_val signed):
  - beq: rs==rt
  - bne: rs!=rt
  - bgez/bgezal: rs>=0
  - bgtz: rs>0
  - blez: rs<=0
  - bltz/bltzal: rs<0
- Taken: redirect=1 and redirect_pc=target. If FLUSH_SLOTS>0, go to SQUASH with cnt=FLUSH_SLOTS and flush=1.
- Not taken: redirect=0; redirect_pc holds its previous value.
- Link write is independent of taken:
  - jal, bgezal, bltzal: link_we=1, link_addr=LINK_REG.
  - jalr: link_we=1, link_addr=rd. If rd==0, link_we=0.
  - link_data = pc+8 (wraps).

SQUASH:
- Each accept drops the beat: no redirect, no link, squash=1 next cycle, cnt decrements.
- When cnt reaches 0, go to IDLE and flush=0 on that same edge.
- Cycles with in_valid=0 or stall=1 do not decrement cnt.

Test Plan:
- beq, pc=0x00400000, imm16=0xFFFF, rs=rt=5 -> next cycle redirect=1, redirect_pc=0x00400000. flush=1 for the next two accepted beats, squash pulses twice, then IDLE.
- bltzal, pc=0x100, rs=1 (not taken) -> redirect=0, link_we=1, link_addr=31, link_data=0x108, flush stays 0.
- jalr, rs=0x8000_0000, rd=0, pc=0xFFFFFFFC -> redirect_pc=0x80000000, link_we=0. Repeat with rd=5 -> link_addr=5, link_data=0x00000004 (wrap).
- jal=2 and jr=1 together, rs=0x40 -> multi_err=1, redirect_pc=0x40, link_we=0.
- Taken j, then stall=1 for 3 cycles in SQUASH with in_valid=1 -> cnt holds, flush stays 1. Deassert rst_n mid-squash -> all outputs 0 immediately, next beat processed normally.
- bgtz with rs=0 -> not taken, no pulses. bgtz with rs=0x7FFFFFFF -> taken.

Source files
------------

// File: rtl/branch_resolve_if.sv
// rtl/branch_resolve_if.sv - EX-stage branch/jump resolve bundle between ID/EX and branch_resolve
interface branch_resolve_if;
    logic        in_valid;
    logic        stall;
    logic [3:0]  branch;
    logic [1:0]  jal;
    logic [1:0]  jr;
    logic [31:0] pc;
    logic [15:0] imm16;
    logic [25:0] instr_index;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [4:0]  rd;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        link_we;
    logic [4:0]  link_addr;
    logic [31:0] link_data;
    logic        flush;
    logic        squash;
    logic        multi_err;

    modport master (
        output in_valid, stall, branch, jal, jr, pc, imm16, instr_index, rs_val, rt_val, rd,
        input  redirect, redirect_pc, link_we, link_addr, link_data, flush, squash, multi_err
    );

    modport slave (
        input  in_valid, stall, branch, jal, jr, pc, imm16, instr_index, rs_val, rt_val, rd,
        output redirect, redirect_pc, link_we, link_addr, link_data, flush, squash, multi_err
    );
endinterface

// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - EX-stage branch resolve, link write and wrong-path squash
module branch_resolve #(
    parameter int FLUSH_SLOTS = 2,
    parameter int LINK_REG    = 31
) (
    input  logic             clk,
    input  logic             rst_n,
    branch_resolve_if.slave  bus
);
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] SQUASH = 1'b1;
    localparam logic [4:0] LINK_ADDR = 5'(LINK_REG);
    localparam logic [3:0] SLOTS     = 4'(FLUSH_SLOTS);

    logic [0:0]  state;
    logic [3:0]  cnt;
    logic        redirect_q, link_we_q, squash_q, multi_err_q;
    logic [31:0] redirect_pc_q, link_data_q;
    logic [4:0]  link_addr_q;

    logic        accept;
    logic        jr_v, jal_v, br_v, multi;
    logic        cond, taken, lwe;
    logic [4:0]  laddr;
    logic [31:0] pc4, br_tgt, tgt;
    logic signed [31:0] rs_s, rt_s;

    assign accept = bus.in_valid & ~bus.stall;

    always_comb begin
        jr_v   = (bus.jr == 2'd1) || (bus.jr == 2'd2);
        jal_v  = (bus.jal == 2'd1) || (bus.jal == 2'd2);
        br_v   = (bus.branch >= 4'd1) && (bus.branch <= 4'd8);
        multi  = (jr_v & jal_v) | (jr_v & br_v) | (jal_v & br_v);
        pc4    = bus.pc + 32'd4;
        br_tgt = pc4 + {{14{bus.imm16[15]}}, bus.imm16, 2'b00};
        rs_s   = $signed(bus.rs_val);
        rt_s   = $signed(bus.rt_val);
        case (bus.branch)
            4'd1:         cond = (rs_s == rt_s);
            4'd2:         cond = (rs_s != rt_s);
            4'd3, 4'd5:   cond = (rs_s >= 32'sd0);
            4'd4:         cond = (rs_s > 32'sd0);
            4'd6:         cond = (rs_s <= 32'sd0);
            4'd7, 4'd8:   cond = (rs_s < 32'sd0);
            default:      cond = 1'b0;
        endcase
        taken = 1'b0;
        tgt   = br_tgt;
        lwe   = 1'b0;
        laddr = LINK_ADDR;
        // Priority jr > jal > branch; lower-priority codes are ignored entirely.
        if (jr_v) begin
            taken = 1'b1;
            tgt   = bus.rs_val;
            if (bus.jr == 2'd2) begin
                laddr = bus.rd;
                lwe   = (bus.rd != 5'd0);
            end
        end else if (jal_v) begin
            taken = 1'b1;
            tgt   = {pc4[31:28], bus.instr_index, 2'b00};
            lwe   = (bus.jal == 2'd2);
        end else if (br_v) begin
            taken = cond;
            lwe   = (bus.branch == 4'd5) || (bus.branch == 4'd8);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= 4'd0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= 32'd0;
            link_we_q     <= 1'b0;
            link_addr_q   <= 5'd0;
            link_data_q   <= 32'd0;
            squash_q      <= 1'b0;
            multi_err_q   <= 1'b0;
        end else begin
            redirect_q  <= 1'b0;
            link_we_q   <= 1'b0;
            squash_q    <= 1'b0;
            multi_err_q <= 1'b0;
            if (accept) begin
                if (state == IDLE) begin
                    multi_err_q <= multi;
                    link_we_q   <= lwe;
                    link_addr_q <= laddr;
                    link_data_q <= bus.pc + 32'd8;
                    if (taken) begin
                        redirect_q    <= 1'b1;
                        redirect_pc_q <= tgt;
                        if (FLUSH_SLOTS > 0) begin
                            state <= SQUASH;
                            cnt   <= SLOTS;
                        end
                    end
                end else begin
                    // Wrong-path beat: drop it and leave SQUASH on the last slot.
                    squash_q <= 1'b1;
                    cnt      <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= IDLE;
                    end
                end
            end
        end
    end

    assign bus.redirect    = redirect_q;
    assign bus.redirect_pc = redirect_pc_q;
    assign bus.link_we     = link_we_q;
    assign bus.link_addr   = link_addr_q;
    assign bus.link_data   = link_data_q;
    assign bus.flush       = (state == SQUASH);
    assign bus.squash      = squash_q;
    assign bus.multi_err   = multi_err_q;
endmodule

// File: tb/tb_branch_resolve.sv
// tb/tb_branch_resolve.sv - directed self-checking bench for branch_resolve
module tb_branch_resolve;
    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    branch_resolve_if bif ();

    branch_resolve #(.FLUSH_SLOTS(2), .LINK_REG(31)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bif.in_valid    = 1'b0;
        bif.stall       = 1'b0;
        bif.branch      = 4'd0;
        bif.jal         = 2'd0;
        bif.jr          = 2'd0;
        bif.pc          = 32'd0;
        bif.imm16       = 16'd0;
        bif.instr_index = 26'd0;
        bif.rs_val      = 32'd0;
        bif.rt_val      = 32'd0;
        bif.rd          = 5'd0;
    endtask

    // Two wrong-path beats after a taken transfer; the second returns to IDLE.
    task automatic drain(input string tag);
        idle_in();
        bif.in_valid = 1'b1;
        bif.jal      = 2'd2;
        cyc();
        chk({tag, "_sq1"}, 32'(bif.squash), 32'd1);
        chk({tag, "_sq1_flush"}, 32'(bif.flush), 32'd1);
        chk({tag, "_sq1_link"}, 32'(bif.link_we), 32'd0);
        cyc();
        chk({tag, "_sq2"}, 32'(bif.squash), 32'd1);
        chk({tag, "_sq2_flush"}, 32'(bif.flush), 32'd0);
        chk({tag, "_sq2_redir"}, 32'(bif.redirect), 32'd0);
        idle_in();
    endtask

    initial begin
        idle_in();
        rst_n = 1'b0;
        #12;
        chk("rst_redirect", 32'(bif.redirect), 32'd0);
        chk("rst_redirect_pc", bif.redirect_pc, 32'd0);
        chk("rst_link_we", 32'(bif.link_we), 32'd0);
        chk("rst_link_data", bif.link_data, 32'd0);
        chk("rst_flush", 32'(bif.flush), 32'd0);
        chk("rst_squash", 32'(bif.squash), 32'd0);
        rst_n = 1'b1;
        cyc();

        // beq taken, offset -1 word lands back on pc
        bif.in_valid = 1'b1;
        bif.branch   = 4'd1;
        bif.pc       = 32'h0040_0000;
        bif.imm16    = 16'hFFFF;
        bif.rs_val   = 32'd5;
        bif.rt_val   = 32'd5;
        cyc();
        chk("beq_redirect", 32'(bif.redirect), 32'd1);
        chk("beq_target", bif.redirect_pc, 32'h0040_0000);
        chk("beq_flush", 32'(bif.flush), 32'd1);
        chk("beq_link_we", 32'(bif.link_we), 32'd0);
        drain("beq");
        cyc();
        chk("beq_after_squash", 32'(bif.squash), 32'd0);
        chk("beq_after_flush", 32'(bif.flush), 32'd0);

        // bltzal not taken still links
        bif.in_valid = 1'b1;
        bif.branch   = 4'd8;
        bif.pc       = 32'h0000_0100;
        bif.rs_val   = 32'd1;
        cyc();
        chk("bltzal_redirect", 32'(bif.redirect), 32'd0);
        chk("bltzal_pc_hold", bif.redirect_pc, 32'h0040_0000);
        chk("bltzal_link_we", 32'(bif.link_we), 32'd1);
        chk("bltzal_link_addr", 32'(bif.link_addr), 32'd31);
        chk("bltzal_link_data", bif.link_data, 32'h0000_0108);
        chk("bltzal_flush", 32'(bif.flush), 32'd0);

        // jalr with rd=0 suppresses link
        idle_in();
        bif.in_valid = 1'b1;
        bif.jr       = 2'd2;
        bif.rs_val   = 32'h8000_0000;
        bif.rd       = 5'd0;
        bif.pc       = 32'hFFFF_FFFC;
        cyc();
        chk("jalr0_redirect", 32'(bif.redirect), 32'd1);
        chk("jalr0_target", bif.redirect_pc, 32'h8000_0000);
        chk("jalr0_link_we", 32'(bif.link_we), 32'd0);
        drain("jalr0");

        bif.in_valid = 1'b1;
        bif.jr       = 2'd2;
        bif.rs_val   = 32'h8000_0000;
        bif.rd       = 5'd5;
        bif.pc       = 32'hFFFF_FFFC;
        cyc();
        chk("jalr5_link_we", 32'(bif.link_we), 32'd1);
        chk("jalr5_link_addr", 32'(bif.link_addr), 32'd5);
        chk("jalr5_link_data", bif.link_data, 32'h0000_0004);
        drain("jalr5");

        // jal and jr together: jr wins, no link
        bif.in_valid = 1'b1;
        bif.jal      = 2'd2;
        bif.jr       = 2'd1;
        bif.rs_val   = 32'h0000_0040;
        bif.pc       = 32'h0000_0300;
        cyc();
        chk("multi_err", 32'(bif.multi_err), 32'd1);
        chk("multi_target", bif.redirect_pc, 32'h0000_0040);
        chk("multi_link_we", 32'(bif.link_we), 32'd0);
        drain("multi");
        cyc();
        chk("multi_err_drop", 32'(bif.multi_err), 32'd0);

        // j taken, then stall 3 cycles inside SQUASH
        bif.in_valid    = 1'b1;
        bif.jal         = 2'd1;
        bif.pc          = 32'h1000_0000;
        bif.instr_index = 26'h000_0010;
        cyc();
        chk("j_redirect", 32'(bif.redirect), 32'd1);
        chk("j_target", bif.redirect_pc, 32'h1000_0040);
        chk("j_link_we", 32'(bif.link_we), 32'd0);
        bif.jal   = 2'd0;
        bif.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall_flush", 32'(bif.flush), 32'd1);
            chk("stall_squash", 32'(bif.squash), 32'd0);
            chk("stall_redirect", 32'(bif.redirect), 32'd0);
        end
        bif.stall = 1'b0;
        cyc();
        chk("post_stall_squash", 32'(bif.squash), 32'd1);
        chk("post_stall_flush", 32'(bif.flush), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_flush", 32'(bif.flush), 32'd0);
        chk("midrst_squash", 32'(bif.squash), 32'd0);
        chk("midrst_redirect_pc", bif.redirect_pc, 32'd0);
        chk("midrst_link_data", bif.link_data, 32'd0);
        #1;
        rst_n = 1'b1;

        // bgtz rs=0: not taken, no pulses, not squashed
        idle_in();
        bif.in_valid = 1'b1;
        bif.branch   = 4'd4;
        bif.pc       = 32'h0000_0200;
        bif.imm16    = 16'd3;
        bif.rs_val   = 32'd0;
        cyc();
        chk("bgtz0_redirect", 32'(bif.redirect), 32'd0);
        chk("bgtz0_squash", 32'(bif.squash), 32'd0);
        chk("bgtz0_link_we", 32'(bif.link_we), 32'd0);
        chk("bgtz0_flush", 32'(bif.flush), 32'd0);
        chk("bgtz0_multi", 32'(bif.multi_err), 32'd0);

        bif.rs_val = 32'h7FFF_FFFF;
        cyc();
        chk("bgtz_redirect", 32'(bif.redirect), 32'd1);
        chk("bgtz_target", bif.redirect_pc, 32'h0000_0210);
        drain("bgtz");

        // bltz with negative rs checks signed compare
        bif.in_valid = 1'b1;
        bif.branch   = 4'd7;
        bif.pc       = 32'h0000_1000;
        bif.imm16    = 16'h0010;
        bif.rs_val   = 32'hFFFF_FFFF;
        cyc();
        chk("bltz_redirect", 32'(bif.redirect), 32'd1);
        chk("bltz_target", bif.redirect_pc, 32'h0000_1044);
        chk("bltz_link_we", 32'(bif.link_we), 32'd0);
        drain("bltz");

        // bne equal operands: not taken
        bif.in_valid = 1'b1;
        bif.branch   = 4'd2;
        bif.rs_val   = 32'd9;
        bif.rt_val   = 32'd9;
        cyc();
        chk("bne_eq_redirect", 32'(bif.redirect), 32'd0);
        chk("bne_eq_flush", 32'(bif.flush), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
